window_addr_gen: RTL and testbench
==================================

WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
- REQ-001: Parameter IMG_W, default 30, feature-map width in pixels.
- REQ-002: Parameter IMG_H, default 16, feature-map height in pixels.
- REQ-003: Parameter K, default 3, square kernel size (odd, 1..7).
- REQ-004: Parameter STRIDE, default 1, window step in both dimensions (1..K).
- REQ-005: Single clock and asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
- REQ-006: start input 1: one-cycle frame request, sampled only in IDLE.
- REQ-007: mode_in input 1: storage layout select, latched at start.
- REQ-008: base_addr input 15: frame base linear address, latched at start.
- REQ-009: addr_ready input 1: downstream address-mapper accepts the current beat.
- REQ-010: addr_valid output 1: dataaddr/mode/pad/last are valid.
- REQ-011: dataaddr output 15: linear pixel address to the address mapper.
- REQ-012: mode output 1: latched mode_in, forwarded to the mapper.
- REQ-013: pad output 1: current beat is a zero-padding position.
- REQ-014: last output 1: current beat is the final beat of the frame.
- REQ-015: busy output 1: high from the cycle after accepted start until done.
- REQ-016: done output 1: one-cycle pulse after the final beat is accepted.

Function
- REQ-017: FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on accepted beat with last=1; DONE->IDLE unconditionally after one cycle.
- REQ-018: start is ignored in RUN and DONE; base_addr and mode_in are not re-sampled mid-frame.
- REQ-019: Beat order, innermost first: kx 0..K-1, ky 0..K-1, window column, window row.
- REQ-020: Without padding, window origins are row r, col c with r = 0, STRIDE, ... <= IMG_H-K and c = 0, STRIDE, ... <= IMG_W-K.
- REQ-021: dataaddr = (base_addr + (r+ky)*IMG_W + (c+kx)) modulo 2^15; all outputs registered.
- REQ-022: addr_valid rises on the first clk edge after start is accepted, carrying window (0,0), kx=ky=0.
- REQ-023: A beat transfers on a cycle with addr_valid=1 and addr_ready=1; the next beat is presented on the following edge, giving one beat per cycle under continuous ready.
- REQ-024: While addr_valid=1 and addr_ready=0, dataaddr, mode, pad and last hold stable, and addr_valid stays 1.
- REQ-025: last=1 only on kx=ky=K-1 of the final window; addr_valid drops on the edge after that beat transfers; done pulses in DONE.
- REQ-026: In IDLE and DONE: addr_valid=0, last=0, pad=0; dataaddr and mode hold their previous values.

Reset
- REQ-027: rst_n low forces immediately: state=IDLE, all counters=0, addr_valid=0, dataaddr=0, mode=0, pad=0, last=0, busy=0, done=0.
- REQ-028: Reset mid-frame abandons the frame; the next start restarts from window (0,0) at the new base_addr.

Configuration
- REQ-029: Macro WAG_PAD_EN defined: P=(K-1)/2 zero-padding enabled.
  - Window origins are (r-P, c-P) for r = 0, STRIDE, ... < IMG_H and c = 0, STRIDE, ... < IMG_W.
  - Beats whose pixel falls outside 0..IMG_H-1 or 0..IMG_W-1 drive pad=1 and dataaddr=0.
  - In-image beats use REQ-021 with the signed coordinates.
- REQ-030: Macro WAG_PAD_EN undefined: no padding logic is built, REQ-020 applies, and pad is tied 0.

Verification
- REQ-031: Reset, start with base_addr=0, mode_in=1, addr_ready=1 -> first nine dataaddr 0,1,2,30,31,32,60,61,62; mode=1; pad=0.
- REQ-032: Same as REQ-031 with addr_ready=0 for 3 cycles while beat 4 is presented -> dataaddr holds 30 with addr_valid=1 for 4 cycles total; next beat is 31.
- REQ-033: Full frame with defaults, no padding, ready=1 -> exactly 28*14*9=3528 beats; final dataaddr=479 with last=1; done pulses once, one cycle later; busy returns to 0.
- REQ-034: base_addr=32760, mode_in=0 -> beats 32760, 32761, 32762, then 22 (wrapped); mode=0.
- REQ-035: rst_n low after 100 accepted beats -> addr_valid=0 immediately; subsequent start with base_addr=0 produces first dataaddr=0.
- REQ-036: WAG_PAD_EN defined, defaults, base_addr=0 -> first beat pad=1 with dataaddr=0; beat 5 (ky=1, kx=1) pad=0 with dataaddr=0; beat 6 dataaddr=1; total beats 30*16*9=4320.

Source files
------------

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - sliding-window pixel address generator for a KxK convolution frame
//
// Purpose: walks every KxK window of an IMG_W x IMG_H feature map, one pixel
// address per beat. Beats are ordered kx, then ky, then window column, then
// window row, innermost first. Each beat is offered to a downstream address
// mapper with a valid/ready handshake.
//
// Configuration macro: WAG_PAD_EN
//   defined   - zero padding of P=(K-1)/2 on every side; out-of-image beats
//               drive pad=1 and dataaddr=0
//   undefined - only fully in-image windows are walked; pad is tied 0
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            one-cycle frame request, only honoured while idle
//   mode_in          storage layout select, latched at start
//   base_addr[14:0]  frame base linear address, latched at start
//   addr_ready       downstream accepts the current beat
//   addr_valid       dataaddr/mode/pad/last are valid
//   dataaddr[14:0]   linear pixel address, modulo 2^15
//   mode             latched mode_in
//   pad              current beat is a zero-padding position
//   last             current beat is the final beat of the frame
//   busy             frame in progress
//   done             one-cycle pulse after the final beat is accepted
module window_addr_gen #(
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 16,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode_in,
  input  logic [14:0] base_addr,
  input  logic        addr_ready,
  output logic        addr_valid,
  output logic [14:0] dataaddr,
  output logic        mode,
  output logic        pad,
  output logic        last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

`ifdef WAG_PAD_EN
  localparam int P     = (K - 1) / 2;
  localparam int C_LIM = IMG_W - 1;
  localparam int R_LIM = IMG_H - 1;
  localparam logic [16:0] P17   = 17'(P);
  localparam logic [16:0] W_P17 = 17'(IMG_W + P);
  localparam logic [16:0] H_P17 = 17'(IMG_H + P);
`else
  localparam int P     = 0;
  localparam int C_LIM = IMG_W - K;
  localparam int R_LIM = IMG_H - K;
`endif

  localparam logic [2:0]  KM1    = 3'(K - 1);
  localparam logic [15:0] STR16  = 16'(STRIDE);
  localparam logic [16:0] STR17  = 17'(STRIDE);
  localparam logic [16:0] CLIM17 = 17'(C_LIM);
  localparam logic [16:0] RLIM17 = 17'(R_LIM);

  state_t      state_q, state_d;
  logic [2:0]  kx_q, kx_d, ky_q, ky_d;
  logic [15:0] c_q, c_d, r_q, r_d;
  logic [14:0] base_q, base_d;
  logic        addr_valid_q, addr_valid_d;
  logic [14:0] dataaddr_q, dataaddr_d;
  logic        mode_q, mode_d;
  logic        pad_q, pad_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Coordinates of the beat that would be presented next: window (0,0) when
  // a frame starts, otherwise the successor of the current beat.
  logic [2:0]  nkx, nky;
  logic [15:0] nc, nr;
  logic [14:0] nbase;
  logic        load;

  logic [14:0] y15, x15, lin15;
  logic [14:0] beat_addr;
  logic        beat_pad;
  logic        beat_last;

  always_comb begin
    nbase = base_q;
    nkx   = kx_q;
    nky   = ky_q;
    nc    = c_q;
    nr    = r_q;
    if (state_q == S_IDLE) begin
      nbase = base_addr;
      nkx   = 3'd0;
      nky   = 3'd0;
      nc    = 16'd0;
      nr    = 16'd0;
    end else if (kx_q != KM1) begin
      nkx = kx_q + 3'd1;
    end else begin
      nkx = 3'd0;
      if (ky_q != KM1) begin
        nky = ky_q + 3'd1;
      end else begin
        nky = 3'd0;
        if (({1'b0, c_q} + STR17) <= CLIM17) begin
          nc = c_q + STR16;
        end else begin
          nc = 16'd0;
          nr = r_q + STR16;
        end
      end
    end
  end

  // Address arithmetic is done modulo 2^15 directly; negative padded
  // coordinates only occur on pad beats, whose address is forced to 0.
  always_comb begin
    y15       = nr[14:0] + {12'd0, nky} - 15'(P);
    x15       = nc[14:0] + {12'd0, nkx} - 15'(P);
    lin15     = nbase + y15 * 15'(IMG_W) + x15;
    beat_last = (nkx == KM1) && (nky == KM1) &&
                (({1'b0, nc} + STR17) > CLIM17) &&
                (({1'b0, nr} + STR17) > RLIM17);
`ifdef WAG_PAD_EN
    // Compare against offset bounds so the unsigned sums never go negative.
    beat_pad  = (({1'b0, nr} + {14'd0, nky}) < P17)   ||
                (({1'b0, nr} + {14'd0, nky}) >= H_P17) ||
                (({1'b0, nc} + {14'd0, nkx}) < P17)   ||
                (({1'b0, nc} + {14'd0, nkx}) >= W_P17);
    beat_addr = beat_pad ? 15'd0 : lin15;
`else
    beat_pad  = 1'b0;
    beat_addr = lin15;
`endif
  end

  always_comb begin
    state_d      = state_q;
    kx_d         = kx_q;
    ky_d         = ky_q;
    c_d          = c_q;
    r_d          = r_q;
    base_d       = base_q;
    addr_valid_d = addr_valid_q;
    dataaddr_d   = dataaddr_q;
    mode_d       = mode_q;
    pad_d        = pad_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          base_d  = base_addr;
          mode_d  = mode_in;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (addr_valid_q && addr_ready) begin
          if (last_q) begin
            state_d      = S_DONE;
            addr_valid_d = 1'b0;
            pad_d        = 1'b0;
            last_d       = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      kx_d         = nkx;
      ky_d         = nky;
      c_d          = nc;
      r_d          = nr;
      addr_valid_d = 1'b1;
      dataaddr_d   = beat_addr;
      pad_d        = beat_pad;
      last_d       = beat_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      kx_q         <= 3'd0;
      ky_q         <= 3'd0;
      c_q          <= 16'd0;
      r_q          <= 16'd0;
      base_q       <= 15'd0;
      addr_valid_q <= 1'b0;
      dataaddr_q   <= 15'd0;
      mode_q       <= 1'b0;
      pad_q        <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      c_q          <= c_d;
      r_q          <= r_d;
      base_q       <= base_d;
      addr_valid_q <= addr_valid_d;
      dataaddr_q   <= dataaddr_d;
      mode_q       <= mode_d;
      pad_q        <= pad_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign addr_valid = addr_valid_q;
  assign dataaddr   = dataaddr_q;
  assign mode       = mode_q;
  assign pad        = pad_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// tb/tb_window_addr_gen.sv - self-checking bench for window_addr_gen
module tb_window_addr_gen;
  localparam int IMG_W  = 30;
  localparam int IMG_H  = 16;
  localparam int K      = 3;
  localparam int STRIDE = 1;
`ifdef WAG_PAD_EN
  localparam int          TOTAL      = 4320;
  localparam logic [14:0] FINAL_ADDR = 15'd0;
`else
  localparam int          TOTAL      = 3528;
  localparam logic [14:0] FINAL_ADDR = 15'd479;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_in = 1'b0;
  logic [14:0] base_addr = 15'd0;
  logic        addr_ready = 1'b0;
  logic        addr_valid;
  logic [14:0] dataaddr;
  logic        mode;
  logic        pad;
  logic        last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
    .base_addr(base_addr), .addr_ready(addr_ready), .addr_valid(addr_valid),
    .dataaddr(dataaddr), .mode(mode), .pad(pad), .last(last),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [14:0] addr;
    logic        mode;
    logic        pad;
    logic        last;
  } beat_t;

  typedef struct {
    logic [14:0] base;
    logic        mode;
    logic [14:0] exp_addr [6];
    logic [5:0]  exp_pad;
  } vec_t;

  beat_t sb[$];
  beat_t got[$];
  beat_t mb, me;
  vec_t  tbl[3];

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int ncyc = 0;
  int last_cyc = -1;
  int done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference walk of the frame straight from the window definition.
  task automatic push_frame(input logic [14:0] b, input logic m);
    int p, rlim, clim, y, x, a;
    beat_t e;
`ifdef WAG_PAD_EN
    p = (K - 1) / 2; rlim = IMG_H - 1; clim = IMG_W - 1;
`else
    p = 0; rlim = IMG_H - K; clim = IMG_W - K;
`endif
    for (int r = 0; r <= rlim; r += STRIDE)
      for (int c = 0; c <= clim; c += STRIDE)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            y = r - p + ky;
            x = c - p + kx;
            e.mode = m;
            e.last = 1'b0;
            e.pad  = (y < 0) || (y >= IMG_H) || (x < 0) || (x >= IMG_W);
            a = int'(b) + y * IMG_W + x;
            e.addr = e.pad ? 15'd0 : a[14:0];
            sb.push_back(e);
          end
    e = sb[sb.size() - 1];
    e.last = 1'b1;
    sb[sb.size() - 1] = e;
  endtask

  // Scoreboard: a beat is taken at the edge following a negedge where both
  // valid and ready are high (ready only changes just after posedge).
  always @(negedge clk) begin
    ncyc++;
    if (rst_n && addr_valid && addr_ready) begin
      mb.addr = dataaddr; mb.mode = mode; mb.pad = pad; mb.last = last;
      got.push_back(mb);
      beats_seen++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got beat addr %0d expected no beat", dataaddr);
      end else begin
        me = sb.pop_front();
        chk("sb_addr", 32'(dataaddr), 32'(me.addr));
        chk("sb_mode", 32'(mode), 32'(me.mode));
        chk("sb_pad",  32'(pad),  32'(me.pad));
        chk("sb_last", 32'(last), 32'(me.last));
      end
      if (last) last_cyc = ncyc;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = ncyc;
      chk("valid_in_done", 32'(addr_valid), 32'd0);
      chk("last_in_done",  32'(last), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_valid",    32'(addr_valid), 32'd0);
    chk("rst_dataaddr", 32'(dataaddr), 32'd0);
    chk("rst_mode",     32'(mode), 32'd0);
    chk("rst_pad",      32'(pad), 32'd0);
    chk("rst_last",     32'(last), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    repeat (2) @(posedge clk);
    sb.delete();
    got.delete();
    beats_seen = 0;
    done_cnt   = 0;
    last_cyc   = -1;
    done_cyc   = -1;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_frame(input logic [14:0] b, input logic m);
    push_frame(b, m);
    start = 1'b1;
    base_addr = b;
    mode_in = m;
    tick();
    start = 1'b0;
    base_addr = 15'($urandom);
    mode_in = ~m;
    chk("valid_after_start", 32'(addr_valid), 32'd1);
    chk("busy_after_start",  32'(busy), 32'd1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beats_seen < n; i++) tick();
    chk("beat_count_reached", 32'(beats_seen >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
`ifdef WAG_PAD_EN
    tbl[0] = '{base: 15'd0,     mode: 1'b1, exp_addr: '{15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd1},         exp_pad: 6'b001111};
    tbl[1] = '{base: 15'd32760, mode: 1'b0, exp_addr: '{15'd0, 15'd0, 15'd0, 15'd0, 15'd32760, 15'd32761}, exp_pad: 6'b001111};
    tbl[2] = '{base: 15'd100,   mode: 1'b1, exp_addr: '{15'd0, 15'd0, 15'd0, 15'd0, 15'd100, 15'd101},     exp_pad: 6'b001111};
`else
    tbl[0] = '{base: 15'd0,     mode: 1'b1, exp_addr: '{15'd0, 15'd1, 15'd2, 15'd30, 15'd31, 15'd32},             exp_pad: 6'b000000};
    tbl[1] = '{base: 15'd32760, mode: 1'b0, exp_addr: '{15'd32760, 15'd32761, 15'd32762, 15'd22, 15'd23, 15'd24}, exp_pad: 6'b000000};
    tbl[2] = '{base: 15'd100,   mode: 1'b1, exp_addr: '{15'd100, 15'd101, 15'd102, 15'd130, 15'd131, 15'd132},     exp_pad: 6'b000000};
`endif

    addr_ready = 1'b1;
    repeat (2) @(posedge clk);

    // First beats of a frame for several bases, including 15-bit wrap.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      addr_ready = 1'b1;
      start_frame(tbl[v].base, tbl[v].mode);
      wait_beats(6, 50);
      if (got.size() >= 6) begin
        for (int j = 0; j < 6; j++) begin
          chk("tbl_addr", 32'(got[j].addr), 32'(tbl[v].exp_addr[j]));
          chk("tbl_pad",  32'(got[j].pad),  32'(tbl[v].exp_pad[j]));
        end
        chk("tbl_mode", 32'(got[0].mode), 32'(tbl[v].mode));
      end
    end

    // Backpressure while the fourth beat is presented.
    do_reset();
    addr_ready = 1'b1;
    start_frame(tbl[0].base, tbl[0].mode);
    wait_beats(3, 50);
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(addr_valid), 32'd1);
      chk("stall_addr",  32'(dataaddr), 32'(tbl[0].exp_addr[3]));
      tick();
    end
    addr_ready = 1'b1;
    chk("stall_valid_final", 32'(addr_valid), 32'd1);
    chk("stall_addr_final",  32'(dataaddr), 32'(tbl[0].exp_addr[3]));
    wait_beats(5, 50);
    if (got.size() >= 5) chk("after_stall_addr", 32'(got[4].addr), 32'(tbl[0].exp_addr[4]));

    // Reset mid-frame, then restart from window (0,0).
    do_reset();
    addr_ready = 1'b1;
    start_frame(15'd500, 1'b1);
    wait_beats(100, 200);
    do_reset();
    addr_ready = 1'b1;
    start_frame(tbl[0].base, tbl[0].mode);
    wait_beats(1, 20);
    if (got.size() >= 1) chk("restart_addr", 32'(got[0].addr), 32'(tbl[0].exp_addr[0]));

    // Full frame with a stray start mid-frame that must be ignored.
    do_reset();
    addr_ready = 1'b1;
    start_frame(15'd0, 1'b0);
    wait_beats(50, 100);
    start = 1'b1;
    base_addr = 15'd1234;
    mode_in = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_mid_frame", 32'(busy), 32'd1);
    wait_done(TOTAL + 100);
    chk("total_beats", 32'(beats_seen), 32'(TOTAL));
    if (got.size() > 0) begin
      chk("final_addr", 32'(got[got.size() - 1].addr), 32'(FINAL_ADDR));
      chk("final_last", 32'(got[got.size() - 1].last), 32'd1);
    end
    chk("done_latency", 32'(done_cyc), 32'(last_cyc + 1));
    repeat (3) tick();
    chk("done_once",      32'(done_cnt), 32'd1);
    chk("busy_after",     32'(busy), 32'd0);
    chk("valid_after",    32'(addr_valid), 32'd0);
    chk("addr_hold_idle", 32'(dataaddr), 32'(FINAL_ADDR));
    chk("sb_drained",     32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
